// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes an instruction bundle into ALU control/operands
// and holds it in a one-entry valid/ready pipeline register with flush.
module alu_issue_stage #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic [4:0]        shamt_in,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [15:0]       imm16,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        ALU_Control,
   output logic [DATA_W-1:0] InputData1,
   output logic [DATA_W-1:0] InputData2,
   output logic [4:0]        shamt,
   output logic              illegal
);

   localparam int unsigned IMM_W   = 16;
   localparam int unsigned CTRL_W  = 4;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned EXT_W   = DATA_W - IMM_W;

   typedef enum logic [CTRL_W-1:0] {
      ALU_NONE = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_SLL  = 4'd3,
      ALU_SRL  = 4'd4,
      ALU_AND  = 4'd5,
      ALU_OR   = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLTU = 4'd8,
      ALU_SLT  = 4'd9
   } alu_op_e;

   typedef struct packed {
      alu_op_e             ctrl;
      logic [DATA_W-1:0]   op1;
      logic [DATA_W-1:0]   op2;
      logic [SHAMT_W-1:0]  sh;
      logic                ill;
   } dec_t;

   logic [DATA_W-1:0] imm_se;
   logic [DATA_W-1:0] imm_ze;
   dec_t              dec_c;
   logic              accept;

   assign imm_se   = {{EXT_W{imm16[IMM_W-1]}}, imm16};
   assign imm_ze   = {{EXT_W{1'b0}}, imm16};
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Instruction decode; undecodable bundles become an all-zero trap bundle.
   always_comb begin
      dec_c      = '0;
      dec_c.op1  = rs_data;
      dec_c.op2  = imm_se;
      unique case (opcode)
         6'h00: begin
            dec_c.op2 = rt_data;
            dec_c.sh  = shamt_in;
            case (funct)
               6'h20, 6'h21: dec_c.ctrl = ALU_ADD;
               6'h22, 6'h23: dec_c.ctrl = ALU_SUB;
               6'h00:        dec_c.ctrl = ALU_SLL;
               6'h02:        dec_c.ctrl = ALU_SRL;
               6'h24:        dec_c.ctrl = ALU_AND;
               6'h25:        dec_c.ctrl = ALU_OR;
               6'h27:        dec_c.ctrl = ALU_NOR;
               6'h2B:        dec_c.ctrl = ALU_SLTU;
               6'h2A:        dec_c.ctrl = ALU_SLT;
               default:      dec_c.ill  = 1'b1;
            endcase
         end
         6'h08, 6'h09, 6'h23, 6'h2B: dec_c.ctrl = ALU_ADD;
         6'h04, 6'h05: begin
            dec_c.ctrl = ALU_SUB;
            dec_c.op2  = rt_data;
         end
         6'h0A: dec_c.ctrl = ALU_SLT;
         6'h0B: dec_c.ctrl = ALU_SLTU;
         6'h0C: begin
            dec_c.ctrl = ALU_AND;
            dec_c.op2  = imm_ze;
         end
         6'h0D: begin
            dec_c.ctrl = ALU_OR;
            dec_c.op2  = imm_ze;
         end
         6'h0F: begin
            dec_c.ctrl = ALU_SLL;
            dec_c.op2  = imm_ze;
            dec_c.sh   = SHAMT_W'(IMM_W);
         end
         default: dec_c.ill = 1'b1;
      endcase
      if (dec_c.ill) begin
         dec_c     = '0;
         dec_c.ill = 1'b1;
      end
   end

   // Pipeline register: flush beats load, load beats drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         ALU_Control <= '0;
         InputData1  <= '0;
         InputData2  <= '0;
         shamt       <= '0;
         illegal     <= 1'b0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         illegal     <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         ALU_Control <= dec_c.ctrl;
         InputData1  <= dec_c.op1;
         InputData2  <= dec_c.op2;
         shamt       <= dec_c.sh;
         illegal     <= dec_c.ill;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode vector table, hand-written
// stall/flush/reset sequences and randomized traffic against a reference model.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt_in;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [15:0] imm16;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  ALU_Control;
   logic [31:0] InputData1;
   logic [31:0] InputData2;
   logic [4:0]  shamt;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct(funct), .shamt_in(shamt_in),
      .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .ALU_Control(ALU_Control),
      .InputData1(InputData1), .InputData2(InputData2), .shamt(shamt),
      .illegal(illegal)
   );

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic        ill;
   } bundle_t;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  sa;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [15:0] imm;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic        ill;
   } vec_t;

   // Reference model state: expected contents of the output register.
   logic    m_valid;
   bundle_t m_out;

   function automatic bundle_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [4:0] sa, input logic [31:0] a,
                                          input logic [31:0] b, input logic [15:0] imm);
      bundle_t r;
      logic [31:0] se;
      logic [31:0] ze;
      se = 32'($signed(imm));
      ze = 32'(imm);
      r  = '{ctrl: 4'd0, a: a, b: se, sh: 5'd0, ill: 1'b0};
      if (op == 6'h00) begin
         r.b  = b;
         r.sh = sa;
         if (fn == 6'h20 || fn == 6'h21)      r.ctrl = 4'd1;
         else if (fn == 6'h22 || fn == 6'h23) r.ctrl = 4'd2;
         else if (fn == 6'h00)                r.ctrl = 4'd3;
         else if (fn == 6'h02)                r.ctrl = 4'd4;
         else if (fn == 6'h24)                r.ctrl = 4'd5;
         else if (fn == 6'h25)                r.ctrl = 4'd6;
         else if (fn == 6'h27)                r.ctrl = 4'd7;
         else if (fn == 6'h2B)                r.ctrl = 4'd8;
         else if (fn == 6'h2A)                r.ctrl = 4'd9;
         else                                 r.ill  = 1'b1;
      end else if (op inside {6'h08, 6'h09, 6'h23, 6'h2B}) r.ctrl = 4'd1;
      else if (op inside {6'h04, 6'h05}) begin r.ctrl = 4'd2; r.b = b; end
      else if (op == 6'h0A) r.ctrl = 4'd9;
      else if (op == 6'h0B) r.ctrl = 4'd8;
      else if (op == 6'h0C) begin r.ctrl = 4'd5; r.b = ze; end
      else if (op == 6'h0D) begin r.ctrl = 4'd6; r.b = ze; end
      else if (op == 6'h0F) begin r.ctrl = 4'd3; r.b = ze; r.sh = 5'd16; end
      else r.ill = 1'b1;
      if (r.ill) r = '{ctrl: 4'd0, a: 32'd0, b: 32'd0, sh: 5'd0, ill: 1'b1};
      return r;
   endfunction

   function automatic logic [74:0] dut_outs();
      return {out_valid, ALU_Control, InputData1, InputData2, shamt, illegal};
   endfunction

   task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sa, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm);
      in_valid = v; opcode = op; funct = fn; shamt_in = sa;
      rs_data = rs; rt_data = rt; imm16 = imm;
   endtask

   // One clock: check in_ready, advance the model on the edge, check outputs after.
   task automatic tick(input string name);
      logic acc;
      #1;
      chk({name, ".in_ready"}, 75'(in_ready), 75'(!m_valid || out_ready));
      acc = in_valid && (!m_valid || out_ready);
      @(posedge clk);
      if (flush) begin
         m_valid = 1'b0;
         m_out.ill = 1'b0;
      end else if (acc) begin
         m_valid = 1'b1;
         m_out = ref_decode(opcode, funct, shamt_in, rs_data, rt_data, imm16);
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      #1;
      chk({name, ".outs"}, dut_outs(), {m_valid, m_out});
   endtask

   vec_t vecs[15];
   logic [5:0] legal_ops[12];
   logic [5:0] legal_fns[11];
   logic [74:0] held;

   initial begin
      vecs[0]  = '{6'h00, 6'h20, 5'd3,  32'd5,        32'd7,        16'h0000, 4'd1, 32'd5,        32'd7,        5'd3,  1'b0};
      vecs[1]  = '{6'h08, 6'h00, 5'd9,  32'd10,       32'd3,        16'hFFFE, 4'd1, 32'd10,       32'hFFFFFFFE, 5'd0,  1'b0};
      vecs[2]  = '{6'h0C, 6'h00, 5'd1,  32'd10,       32'd3,        16'hFFFE, 4'd5, 32'd10,       32'h0000FFFE, 5'd0,  1'b0};
      vecs[3]  = '{6'h0F, 6'h11, 5'd2,  32'd99,       32'd4,        16'h1234, 4'd3, 32'd99,       32'h00001234, 5'd16, 1'b0};
      vecs[4]  = '{6'h00, 6'h23, 5'd0,  32'hA,        32'hB,        16'h1111, 4'd2, 32'hA,        32'hB,        5'd0,  1'b0};
      vecs[5]  = '{6'h04, 6'h3A, 5'd7,  32'h1,        32'h55,       16'h8000, 4'd2, 32'h1,        32'h55,       5'd0,  1'b0};
      vecs[6]  = '{6'h0A, 6'h00, 5'd0,  32'h77,       32'h0,        16'h8000, 4'd9, 32'h77,       32'hFFFF8000, 5'd0,  1'b0};
      vecs[7]  = '{6'h0B, 6'h00, 5'd0,  32'h78,       32'h0,        16'h7FFF, 4'd8, 32'h78,       32'h00007FFF, 5'd0,  1'b0};
      vecs[8]  = '{6'h0D, 6'h00, 5'd0,  32'hF0F0F0F0, 32'h0,        16'h8001, 4'd6, 32'hF0F0F0F0, 32'h00008001, 5'd0,  1'b0};
      vecs[9]  = '{6'h00, 6'h27, 5'd31, 32'h12345678, 32'h9ABCDEF0, 16'h0,    4'd7, 32'h12345678, 32'h9ABCDEF0, 5'd31, 1'b0};
      vecs[10] = '{6'h00, 6'h2A, 5'd4,  32'h1,        32'h2,        16'h0,    4'd9, 32'h1,        32'h2,        5'd4,  1'b0};
      vecs[11] = '{6'h00, 6'h02, 5'd8,  32'hFF,       32'hEE,       16'h0,    4'd4, 32'hFF,       32'hEE,       5'd8,  1'b0};
      vecs[12] = '{6'h3F, 6'h20, 5'd5,  32'hDEAD,     32'hBEEF,     16'h1234, 4'd0, 32'h0,        32'h0,        5'd0,  1'b1};
      vecs[13] = '{6'h00, 6'h01, 5'd5,  32'hDEAD,     32'hBEEF,     16'h1234, 4'd0, 32'h0,        32'h0,        5'd0,  1'b1};
      vecs[14] = '{6'h2B, 6'h00, 5'd5,  32'h100,      32'h3,        16'h0004, 4'd1, 32'h100,      32'h00000004, 5'd0,  1'b0};
      legal_ops = '{6'h00, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F};
      legal_fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h00, 6'h02, 6'h24, 6'h25, 6'h27, 6'h2B, 6'h2A};

      // Reset
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      set_in(1'b0, 6'h0, 6'h0, 5'd0, 32'd0, 32'd0, 16'd0);
      m_valid = 1'b0; m_out = '0;
      #12;
      chk("reset.outs", dut_outs(), 75'd0);
      chk("reset.in_ready", 75'(in_ready), 75'd1);
      rst_n = 1'b1;

      // Decode table, back-to-back at full throughput
      for (int i = 0; i < 15; i++) begin
         set_in(1'b1, vecs[i].op, vecs[i].fn, vecs[i].sa, vecs[i].rs, vecs[i].rt, vecs[i].imm);
         tick($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.table", i), dut_outs(),
             {1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].ill});
      end
      in_valid = 1'b0;
      tick("drain");
      chk("drain.valid", 75'(out_valid), 75'd0);

      // Stall for 3 cycles with toggling inputs, then back-to-back release
      set_in(1'b1, 6'h00, 6'h25, 5'd1, 32'h11, 32'h22, 16'h0);
      tick("stall.load");
      held = dut_outs();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 6'h08, 6'h00, 5'd0, $urandom, $urandom, 16'($urandom));
         #1;
         chk("stall.in_ready_low", 75'(in_ready), 75'd0);
         tick("stall");
         chk("stall.hold", dut_outs(), held);
      end
      out_ready = 1'b1;
      set_in(1'b1, 6'h0D, 6'h00, 5'd0, 32'h33, 32'h44, 16'hABCD);
      tick("release");
      chk("release.no_bubble", dut_outs(), {1'b1, 4'd6, 32'h33, 32'h0000ABCD, 5'd0, 1'b0});

      // Flush with a valid bundle held and a new one offered
      set_in(1'b1, 6'h3F, 6'h00, 5'd0, 32'h1, 32'h2, 16'h3);
      tick("illegal.load");
      chk("illegal.flag", dut_outs(), {1'b1, 4'd0, 32'h0, 32'h0, 5'd0, 1'b1});
      set_in(1'b1, 6'h00, 6'h20, 5'd2, 32'h99, 32'h98, 16'h0);
      flush = 1'b1;
      tick("flush");
      chk("flush.dropped", dut_outs(), {1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0});
      flush = 1'b0;

      // Async reset in the middle of a stall
      set_in(1'b1, 6'h00, 6'h22, 5'd9, 32'h5555, 32'h6666, 16'h0);
      tick("rst.load");
      out_ready = 1'b0;
      in_valid  = 1'b0;
      tick("rst.stall");
      #2;
      rst_n = 1'b0;
      #1;
      m_valid = 1'b0; m_out = '0;
      chk("rst.async_clear", dut_outs(), 75'd0);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         logic [5:0] op;
         logic [5:0] fn;
         op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 11)];
         fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 10)];
         set_in(1'($urandom_range(0, 3) != 0), op, fn, 5'($urandom), $urandom, $urandom,
                16'($urandom));
         out_ready = 1'($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer end of the ALU operand/control interface.
- Accepts a decoded-register-read instruction bundle (opcode, funct, shamt, rs/rt data, imm16) over a valid/ready handshake.
- Translates it into the ALU's 4-bit operation code, two 32-bit operands and shift amount, and holds them in a one-entry pipeline register.
- Sits between register read (ID) and the ALU (EX), with stall back-pressure and flush support.

Parameters:
- DATA_W, 32, operand width; the only supported value is 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream bundle valid
- in_ready  output  1  stage can accept a bundle this cycle
- opcode  input  6  instruction [31:26]
- funct  input  6  instruction [5:0]
- shamt_in  input  5  instruction [10:6]
- rs_data  input  32  register rs value
- rt_data  input  32  register rt value
- imm16  input  16  instruction [15:0]
- flush  input  1  discard held bundle (branch/exception)
- out_valid  output  1  ALU bundle valid
- out_ready  input  1  downstream (EX) accepts bundle
- ALU_Control  output  4  ALU operation code
- InputData1  output  32  ALU operand 1
- InputData2  output  32  ALU operand 2
- shamt  output  5  ALU shift amount
- illegal  output  1  held bundle is an undecodable instruction

Behaviour:
- Reset (async, rst_n=0): out_valid=0, ALU_Control=0, InputData1=0, InputData2=0, shamt=0, illegal=0.
- in_ready = !out_valid | out_ready. This is combinational, with no dependence on in_valid.
- Load: on a clk edge with in_valid & in_ready, all outputs register the decode of the current inputs and out_valid becomes 1.
  - Latency: 1 cycle from accept to out_valid.
  - Full throughput when out_ready stays high.
- Drain: on an edge with out_valid & out_ready & !(in_valid & in_ready), out_valid becomes 0. Data outputs hold their last values.
- Stall: out_valid & !out_ready means every output holds and in_ready=0.
- Flush (priority over load): on an edge with flush=1, out_valid becomes 0 and illegal becomes 0, and any same-cycle input is dropped. in_ready is still computed normally.
- Operation codes:
  - 1 ADD, 2 SUB, 3 SLL, 4 SRL, 5 AND, 6 OR, 7 NOR, 8 SLTU, 9 SLT, 0 none.
  - Sign-extend (SE) means {{16{imm16[15]}}, imm16].
  - Zero-extend (ZE) means {16'b0, imm16}.
- R-type (opcode 0x00):
  - Default operands: InputData1=rs_data, InputData2=rt_data, shamt=shamt_in.
  - funct 0x20/0x21 -> 1
  - funct 0x22/0x23 -> 2
  - funct 0x00 -> 3
  - funct 0x02 -> 4
  - funct 0x24 -> 5
  - funct 0x25 -> 6
  - funct 0x27 -> 7
  - funct 0x2B -> 8
  - funct 0x2A -> 9
- I-type: InputData1=rs_data, shamt=0 unless stated.
  - 0x08/0x09 addi(u) -> 1, SE
  - 0x23 lw, 0x2B sw -> 1, SE
  - 0x04 beq, 0x05 bne -> 2, InputData2=rt_data
  - 0x0A slti -> 9, SE
  - 0x0B sltiu -> 8, SE
  - 0x0C andi -> 5, ZE
  - 0x0D ori -> 6, ZE
  - 0x0F lui -> 3, InputData2=ZE, shamt=16
- Any other opcode, or an undefined R-type funct: ALU_Control=0, InputData1=0, InputData2=0, shamt=0, illegal=1. The bundle still handshakes normally, so the trap is visible downstream.
- Simultaneous accept and drain in one cycle: the new bundle replaces the old one, out_valid stays 1, and there is no bubble.
- Reset asserted mid-stall: outputs clear immediately, independent of clk.

Test Plan:
- Reset, then R-type add: opcode=0x00, funct=0x20, rs_data=5, rt_data=7, out_ready=1 -> next cycle out_valid=1, ALU_Control=1, InputData1=5, InputData2=7.
- addi with imm16=0xFFFE, rs_data=10 -> ALU_Control=1, InputData2=0xFFFFFFFE; andi with imm16=0xFFFE -> ALU_Control=5, InputData2=0x0000FFFE.
- lui with imm16=0x1234 -> ALU_Control=3, InputData2=0x00001234, shamt=16.
- Stall: a bundle is held, out_ready=0 for 3 cycles while new inputs toggle -> in_ready=0 and outputs unchanged. Raise out_ready together with in_valid=1 -> back-to-back transfer with no bubble.
- Flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the input is not captured. Undefined opcode 0x3F -> ALU_Control=0, illegal=1, out_valid=1.
- Assert rst_n=0 between clk edges during a stall -> out_valid and all outputs go to 0 immediately.
